// File: rtl/siphash_sched.sv
// SipHash message scheduler: feeds 64-bit words, length padding and finalize commands to siphash_core.
// Optional cycle counter output perf_cycles is enabled by defining SIPHASH_SCHED_PERF_EN.
module siphash_sched (
    input  logic         clk,
    input  logic         reset,
    input  logic         start,
    input  logic [127:0] key,
    input  logic [3:0]   c_rounds,
    input  logic [3:0]   d_rounds,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [63:0]  in_data,
    input  logic         in_last,
    input  logic [3:0]   in_bytes,
    output logic         busy,
    output logic [63:0]  digest,
    output logic         digest_valid,
    output logic         core_initalize,
    output logic         core_compress,
    output logic         core_finalize,
    output logic         core_long,
    output logic [127:0] core_key,
    output logic [63:0]  core_mi,
    output logic [3:0]   core_compression_rounds,
    output logic [3:0]   core_final_rounds,
    input  logic         core_ready,
    input  logic         core_word_valid,
    input  logic [63:0]  core_word
`ifdef SIPHASH_SCHED_PERF_EN
    ,
    output logic [31:0]  perf_cycles
`endif
);

    localparam int unsigned WORD_W  = 64;
    localparam int unsigned KEY_W   = 128;
    localparam int unsigned LEN_W   = 8;
    localparam int unsigned TAIL_W  = WORD_W - LEN_W;
    localparam int unsigned PERF_W  = 32;

    typedef enum logic [2:0] {
        IDLE, INIT, GET, CWAIT, PAD, FINAL, FWAIT, DONE
    } state_e;

    state_e              state_q, state_d;
    logic [KEY_W-1:0]    key_q, key_d;
    logic [3:0]          crnd_q, crnd_d;
    logic [3:0]          frnd_q, frnd_d;
    logic [LEN_W-1:0]    len_q, len_d;
    logic                pad_done_q, pad_done_d;
    logic                last_seen_q, last_seen_d;
    logic                blk_q, blk_d;
    logic [WORD_W-1:0]   digest_q, digest_d;
    logic                dvalid_q, dvalid_d;
    logic                init_q, init_d;
    logic                comp_q, comp_d;
    logic                fin_q, fin_d;
    logic [WORD_W-1:0]   mi_q, mi_d;
    logic                in_ready_q, in_ready_d;
    logic                busy_q, busy_d;

    logic [3:0]          nbytes_c;
    logic [TAIL_W-1:0]   tail_c;

    // Clamp byte count and keep only the valid low bytes of a partial last word.
    always_comb begin
        nbytes_c = (in_bytes > 4'd8) ? 4'd8 : in_bytes;
        tail_c   = '0;
        for (int i = 0; i < 7; i++) begin
            if (4'(i) < nbytes_c) begin
                tail_c[8*i +: 8] = in_data[8*i +: 8];
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= IDLE;
            key_q       <= '0;
            crnd_q      <= '0;
            frnd_q      <= '0;
            len_q       <= '0;
            pad_done_q  <= 1'b0;
            last_seen_q <= 1'b0;
            blk_q       <= 1'b0;
            digest_q    <= '0;
            dvalid_q    <= 1'b0;
            init_q      <= 1'b0;
            comp_q      <= 1'b0;
            fin_q       <= 1'b0;
            mi_q        <= '0;
            in_ready_q  <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            key_q       <= key_d;
            crnd_q      <= crnd_d;
            frnd_q      <= frnd_d;
            len_q       <= len_d;
            pad_done_q  <= pad_done_d;
            last_seen_q <= last_seen_d;
            blk_q       <= blk_d;
            digest_q    <= digest_d;
            dvalid_q    <= dvalid_d;
            init_q      <= init_d;
            comp_q      <= comp_d;
            fin_q       <= fin_d;
            mi_q        <= mi_d;
            in_ready_q  <= in_ready_d;
            busy_q      <= busy_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        key_d       = key_q;
        crnd_d      = crnd_q;
        frnd_d      = frnd_q;
        len_d       = len_q;
        pad_done_d  = pad_done_q;
        last_seen_d = last_seen_q;
        blk_d       = 1'b0;
        digest_d    = digest_q;
        dvalid_d    = dvalid_q;
        init_d      = 1'b0;
        comp_d      = 1'b0;
        fin_d       = 1'b0;
        mi_d        = mi_q;

        case (state_q)
            IDLE: begin
                if (start) begin
                    key_d       = key;
                    crnd_d      = c_rounds;
                    frnd_d      = d_rounds;
                    len_d       = '0;
                    pad_done_d  = 1'b0;
                    last_seen_d = 1'b0;
                    dvalid_d    = 1'b0;
                    init_d      = 1'b1;
                    state_d     = INIT;
                end
            end
            INIT: state_d = GET;
            GET: begin
                if (in_valid) begin
                    comp_d  = 1'b1;
                    blk_d   = 1'b1;
                    state_d = CWAIT;
                    if (in_last && (nbytes_c < 4'd8)) begin
                        mi_d        = {len_q + LEN_W'(nbytes_c), tail_c};
                        pad_done_d  = 1'b1;
                        last_seen_d = 1'b1;
                    end else begin
                        mi_d  = in_data;
                        len_d = len_q + LEN_W'(8);
                        if (in_last) begin
                            last_seen_d = 1'b1;
                            pad_done_d  = 1'b0;
                        end
                    end
                end
            end
            // First cycle after a command is blocked: core_ready may still be stale.
            CWAIT: begin
                if (!blk_q && core_ready) begin
                    if (!last_seen_q) begin
                        state_d = GET;
                    end else if (!pad_done_q) begin
                        comp_d     = 1'b1;
                        mi_d       = {len_q, TAIL_W'(0)};
                        pad_done_d = 1'b1;
                        state_d    = PAD;
                    end else begin
                        fin_d   = 1'b1;
                        state_d = FINAL;
                    end
                end
            end
            PAD: begin
                blk_d   = 1'b1;
                state_d = CWAIT;
            end
            FINAL: begin
                blk_d   = 1'b1;
                state_d = FWAIT;
            end
            FWAIT: begin
                if (!blk_q && core_word_valid) begin
                    digest_d = core_word;
                    dvalid_d = 1'b1;
                    state_d  = DONE;
                end
            end
            DONE: state_d = IDLE;
            default: state_d = IDLE;
        endcase

        in_ready_d = (state_d == GET);
        busy_d     = (state_d != IDLE);
    end

    assign in_ready                = in_ready_q;
    assign busy                    = busy_q;
    assign digest                  = digest_q;
    assign digest_valid            = dvalid_q;
    assign core_initalize          = init_q;
    assign core_compress           = comp_q;
    assign core_finalize           = fin_q;
    assign core_long               = 1'b0;
    assign core_key                = key_q;
    assign core_mi                 = mi_q;
    assign core_compression_rounds = crnd_q;
    assign core_final_rounds       = frnd_q;

`ifdef SIPHASH_SCHED_PERF_EN
    logic [PERF_W-1:0] perf_q;

    // Busy-cycle counter, restarted by each accepted start, saturating.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            perf_q <= '0;
        end else if ((state_q == IDLE) && start) begin
            perf_q <= '0;
        end else if (busy_q && (perf_q != {PERF_W{1'b1}})) begin
            perf_q <= perf_q + PERF_W'(1);
        end
    end

    assign perf_cycles = perf_q;
`endif

endmodule

// File: tb/tb_siphash_sched.sv
// Scoreboard bench for siphash_sched with a behavioural SipHash core model on the core-side ports.
module tb_siphash_sched;

    localparam logic [127:0] KEY = 128'h0f0e0d0c0b0a0908_0706050403020100;

    typedef struct {
        logic [63:0] dig;
        int          ncomp;
    } exp_t;

    logic         clk = 1'b0;
    logic         reset;
    logic         start;
    logic [127:0] key;
    logic [3:0]   c_rounds, d_rounds;
    logic         in_valid, in_ready, in_last;
    logic [63:0]  in_data;
    logic [3:0]   in_bytes;
    logic         busy, digest_valid;
    logic [63:0]  digest;
    logic         core_initalize, core_compress, core_finalize, core_long;
    logic [127:0] core_key;
    logic [63:0]  core_mi;
    logic [3:0]   core_compression_rounds, core_final_rounds;
    logic         core_ready, core_word_valid;
    logic [63:0]  core_word;
`ifdef SIPHASH_SCHED_PERF_EN
    logic [31:0]  perf_cycles;
`endif

    int   tests = 0;
    int   fails = 0;
    int   n_done = 0;
    int   busy_cnt = 0;
    int   overlap_cnt = 0;
    int   bp_viol = 0;
    int   lat = 3;
    exp_t exp_q[$];

    always #5 clk = ~clk;

    siphash_sched dut (
        .clk(clk), .reset(reset), .start(start), .key(key),
        .c_rounds(c_rounds), .d_rounds(d_rounds),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
        .in_last(in_last), .in_bytes(in_bytes),
        .busy(busy), .digest(digest), .digest_valid(digest_valid),
        .core_initalize(core_initalize), .core_compress(core_compress),
        .core_finalize(core_finalize), .core_long(core_long),
        .core_key(core_key), .core_mi(core_mi),
        .core_compression_rounds(core_compression_rounds),
        .core_final_rounds(core_final_rounds),
        .core_ready(core_ready), .core_word_valid(core_word_valid),
        .core_word(core_word)
`ifdef SIPHASH_SCHED_PERF_EN
        , .perf_cycles(perf_cycles)
`endif
    );

    // ---------------- SipHash core model ----------------
    function automatic logic [63:0] rotl(input logic [63:0] x, input int b);
        return (x << b) | (x >> (64 - b));
    endfunction

    function automatic logic [255:0] sip_round(input logic [255:0] s);
        logic [63:0] v0, v1, v2, v3;
        {v3, v2, v1, v0} = s;
        v0 = v0 + v1; v1 = rotl(v1, 13); v1 = v1 ^ v0; v0 = rotl(v0, 32);
        v2 = v2 + v3; v3 = rotl(v3, 16); v3 = v3 ^ v2;
        v0 = v0 + v3; v3 = rotl(v3, 21); v3 = v3 ^ v0;
        v2 = v2 + v1; v1 = rotl(v1, 17); v1 = v1 ^ v2; v2 = rotl(v2, 32);
        return {v3, v2, v1, v0};
    endfunction

    function automatic logic [255:0] sip_init(input logic [127:0] k);
        logic [63:0] k0, k1;
        k0 = k[63:0];
        k1 = k[127:64];
        return {k1 ^ 64'h7465646279746573, k0 ^ 64'h6c7967656e657261,
                k1 ^ 64'h646f72616e646f6d, k0 ^ 64'h736f6d6570736575};
    endfunction

    function automatic logic [255:0] sip_comp(input logic [255:0] s, input logic [63:0] m,
                                              input logic [3:0] n);
        logic [255:0] t;
        t = s;
        t[255:192] = t[255:192] ^ m;
        for (int i = 0; i < int'(n); i++) t = sip_round(t);
        t[63:0] = t[63:0] ^ m;
        return t;
    endfunction

    function automatic logic [63:0] sip_fin(input logic [255:0] s, input logic [3:0] n);
        logic [255:0] t;
        t = s;
        t[191:128] = t[191:128] ^ 64'hff;
        for (int i = 0; i < int'(n); i++) t = sip_round(t);
        return t[63:0] ^ t[127:64] ^ t[191:128] ^ t[255:192];
    endfunction

    logic [255:0] v;
    int           cnt;
    int           ncomp;
    logic         fin_pend;

    always @(posedge clk or posedge reset) begin
        if (reset) begin
            v <= '0; cnt <= 0; ncomp <= 0; fin_pend <= 1'b0;
            core_ready <= 1'b1; core_word_valid <= 1'b0; core_word <= '0;
        end else if (core_initalize) begin
            v <= sip_init(core_key); ncomp <= 0; core_word_valid <= 1'b0;
        end else if (core_compress) begin
            v <= sip_comp(v, core_mi, core_compression_rounds);
            ncomp <= ncomp + 1; core_ready <= 1'b0; cnt <= lat;
        end else if (core_finalize) begin
            core_word <= sip_fin(v, core_final_rounds);
            core_word_valid <= 1'b0; core_ready <= 1'b0; cnt <= lat; fin_pend <= 1'b1;
        end else if (cnt != 0) begin
            cnt <= cnt - 1;
            if (cnt == 1) begin
                core_ready <= 1'b1;
                if (fin_pend) begin
                    core_word_valid <= 1'b1;
                    fin_pend <= 1'b0;
                end
            end
        end
    end

    // ---------------- checking ----------------
    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Monitor: pops the scoreboard on each new digest, and watches protocol rules every cycle.
    logic prev_dv = 1'b0;
    always @(negedge clk) begin
        if (busy === 1'b1) busy_cnt++;
        if ((int'(core_initalize) + int'(core_compress) + int'(core_finalize)) > 1) overlap_cnt++;
        if (in_ready === 1'b1 && cnt != 0) bp_viol++;
        if (digest_valid === 1'b1 && prev_dv !== 1'b1) begin
            if (exp_q.size() == 0) begin
                tests++; fails++;
                $display("FAIL unexpected_digest: got %h expected none", digest);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                chk("digest", digest, e.dig);
                chk("compress_count", 64'(ncomp), 64'(e.ncomp));
            end
            n_done++;
        end
        prev_dv = digest_valid;
    end

    // ---------------- stimulus ----------------
    task automatic msg_start(input logic [63:0] dig, input int nc);
        exp_t e;
        e.dig = dig; e.ncomp = nc;
        exp_q.push_back(e);
        @(posedge clk); #1;
        start = 1'b1; busy_cnt = 0;
        @(posedge clk); #1;
        start = 1'b0;
    endtask

    task automatic send_word(input logic [63:0] d, input logic last, input logic [3:0] nb);
        bit acc;
        acc = 1'b0;
        in_valid = 1'b1; in_data = d; in_last = last; in_bytes = nb;
        for (int i = 0; i < 200 && !acc; i++) begin
            @(negedge clk);
            acc = in_ready;
            @(posedge clk); #1;
        end
        in_valid = 1'b0; in_data = 64'ha5a5_a5a5_a5a5_a5a5; in_last = 1'b0; in_bytes = 4'd0;
        if (!acc) begin
            tests++; fails++;
            $display("FAIL accept_timeout: got no in_ready expected in_ready within 200 cycles");
        end
    endtask

    task automatic wait_done(input int target);
        for (int i = 0; i < 500 && n_done < target; i++) @(negedge clk);
        if (n_done < target) begin
            tests++; fails++;
            $display("FAIL done_timeout: got %0d digests expected %0d", n_done, target);
        end
    endtask

    initial begin
        reset = 1'b1; start = 1'b0; key = KEY; c_rounds = 4'd2; d_rounds = 4'd4;
        in_valid = 1'b0; in_data = '0; in_last = 1'b0; in_bytes = '0;
        repeat (3) @(negedge clk);
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_dvalid", 64'(digest_valid), 64'd0);
        chk("rst_digest", digest, 64'd0);
        chk("rst_in_ready", 64'(in_ready), 64'd0);
        chk("rst_pulses", 64'({core_initalize, core_compress, core_finalize, core_long}), 64'd0);
        chk("rst_core_mi", core_mi, 64'd0);
        chk("rst_core_key_lo", core_key[63:0], 64'd0);
        @(posedge clk); #1;
        reset = 1'b0;

        // Empty message
        lat = 3;
        msg_start(64'h726fdb47dd0e0e31, 1);
        @(negedge clk);
        chk("run_busy", 64'(busy), 64'd1);
        chk("run_dvalid", 64'(digest_valid), 64'd0);
        chk("core_key_hi", core_key[127:64], KEY[127:64]);
        send_word(64'h0, 1'b1, 4'd0);
        wait_done(1);
        repeat (4) @(negedge clk);
        chk("dvalid_hold", 64'(digest_valid), 64'd1);
        chk("digest_hold", digest, 64'h726fdb47dd0e0e31);
        chk("idle_busy", 64'(busy), 64'd0);
`ifdef SIPHASH_SCHED_PERF_EN
        chk("perf_cycles", 64'(perf_cycles), 64'(busy_cnt));
`endif

        // 8-byte message: extra length-only pad block
        msg_start(64'h93f5f5799a932462, 2);
        @(negedge clk);
        chk("start_clears_dvalid", 64'(digest_valid), 64'd0);
        send_word(64'h0706050403020100, 1'b1, 4'd8);
        wait_done(2);

        // 15-byte message, slow core, non-last in_bytes ignored, start in CWAIT ignored
        lat = 6;
        msg_start(64'ha129ca6149be45e5, 2);
        send_word(64'h0706050403020100, 1'b0, 4'd3);
        start = 1'b1; key = ~KEY; c_rounds = 4'd1;
        @(posedge clk); #1;
        start = 1'b0; key = KEY; c_rounds = 4'd2;
        send_word(64'h000e0d0c0b0a0908, 1'b1, 4'd7);
        wait_done(3);

        // in_bytes above 8 behaves as a full word
        lat = 2;
        msg_start(64'h93f5f5799a932462, 2);
        send_word(64'h0706050403020100, 1'b1, 4'd15);
        wait_done(4);

        // 1-byte message with junk in the unused bytes
        msg_start(64'h74f839c593dc67fd, 1);
        send_word(64'hdeadbeefcafeba00, 1'b1, 4'd1);
        wait_done(5);

        // Reset while waiting on the core aborts the message
        lat = 8;
        @(posedge clk); #1;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        send_word(64'h0706050403020100, 1'b0, 4'd8);
        #2 reset = 1'b1;
        #1;
        chk("abort_busy", 64'(busy), 64'd0);
        chk("abort_dvalid", 64'(digest_valid), 64'd0);
        chk("abort_digest", digest, 64'd0);
        @(posedge clk); #1;
        reset = 1'b0;
        lat = 3;
        msg_start(64'h726fdb47dd0e0e31, 1);
        send_word(64'h0, 1'b1, 4'd0);
        wait_done(6);
        repeat (3) @(negedge clk);

        chk("digest_count", 64'(n_done), 64'd6);
        chk("scoreboard_empty", 64'(exp_q.size()), 64'd0);
        chk("pulse_overlap", 64'(overlap_cnt), 64'd0);
        chk("ready_while_core_busy", 64'(bp_viol), 64'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
